// File: rtl/demux1to4_router_pkg.sv
// Shared constants for the 1-to-4 demultiplexing router.
//   DefaultWidth : default data width of every data port
//   NumCh        : number of destination channels
//   SelWidth     : width of the destination select {S1,S0}
//   CountWidth   : width of the accepted-word counter
package demux1to4_router_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned NumCh        = 4;
  localparam int unsigned SelWidth     = 2;
  localparam int unsigned CountWidth   = 8;

endpackage

// File: rtl/demux_slot.sv
// One-word holding slot for a single router destination.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   load       : transfer into this slot on this edge (already qualified by the top)
//   ack        : destination consumes the held word this cycle
//   data_in    : word to capture on load
//   data       : held word (changes only on load)
//   valid      : held word not yet consumed
module demux_slot #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             ack,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  // A load wins over an ack on the same edge, so pass-through keeps valid high.
  // An ack on an empty slot leaves valid at 0 and is therefore ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      data_q  <= data_in;
      valid_q <= 1'b1;
    end else if (ack) begin
      valid_q <= 1'b0;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/demux1to4_router.sv
// 1-to-4 demultiplexing router with a one-word holding slot per destination.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   S1, S0              : destination select, k = {S1,S0}
//   in_valid, in_data   : source offer
//   in_ready            : router accepts the offer this cycle (combinational)
//   out_data0..3        : held word per destination
//   out_valid[3:0]      : per-destination unconsumed-word flags
//   out_ack[3:0]        : per-destination consume strobes
//   accept_count        : accepted words, modulo 256
module demux1to4_router
  import demux1to4_router_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  S1,
  input  logic                  S0,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data0,
  output logic [WIDTH-1:0]      out_data1,
  output logic [WIDTH-1:0]      out_data2,
  output logic [WIDTH-1:0]      out_data3,
  output logic [NumCh-1:0]      out_valid,
  input  logic [NumCh-1:0]      out_ack,
  output logic [CountWidth-1:0] accept_count
);

  logic [SelWidth-1:0]   sel;
  logic                  fire;
  logic [NumCh-1:0]      load;
  logic [WIDTH-1:0]      slot_data [NumCh];
  logic [CountWidth-1:0] count_q;

  assign sel = {S1, S0};

  // Ready when the selected slot is empty or is being drained this cycle.
  assign in_ready = ~out_valid[sel] | out_ack[sel];
  assign fire     = in_valid & in_ready;

  for (genvar j = 0; j < NumCh; j++) begin : g_slot
    assign load[j] = fire && (sel == SelWidth'(j));

    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk    (clk),
      .reset  (reset),
      .load   (load[j]),
      .ack    (out_ack[j]),
      .data_in(in_data),
      .data   (slot_data[j]),
      .valid  (out_valid[j])
    );
  end

  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (fire) begin
      count_q <= count_q + CountWidth'(1);
    end
  end

  assign accept_count = count_q;

endmodule
